// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared types and helpers for the round-robin stream multiplexer.
//   arb_mode_e  : arbitration policy (ARB_RR rotating priority, ARB_FIXED lowest index)
//   mux_state_e : packet-lock FSM states (IDLE between packets, LOCKED inside one)
//   wrap_inc    : index increment with wrap to zero at n-1
package stream_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_e;

  // Next channel index after idx in a ring of n channels.
  function automatic int wrap_inc(input int idx, input int n);
    int res;
    if (idx >= n - 32'sd1) begin
      res = 32'sd0;
    end else begin
      res = idx + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational masked-priority search. The request at index ptr has the
// highest priority, then ptr+1, ... wrapping around. Driving ptr with zero
// gives plain lowest-index-wins priority.
// Ports:
//   req       : per-channel request vector
//   ptr       : index where the priority search starts (must be < NUM_IN)
//   gnt       : one-hot grant (all zero when no request)
//   gnt_idx   : binary index of the granted channel (0 when none)
//   gnt_valid : at least one request was granted
module rr_arbiter #(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] ptr,
  output logic [NUM_IN-1:0]         gnt,
  output logic [$clog2(NUM_IN)-1:0] gnt_idx,
  output logic                      gnt_valid
);

  localparam int IW = $clog2(NUM_IN);

  // Walk the channels starting at ptr; the first requester found wins.
  always_comb begin
    int j;
    gnt       = {NUM_IN{1'b0}};
    gnt_idx   = {IW{1'b0}};
    gnt_valid = 1'b0;
    j         = 32'sd0;
    for (int i = 0; i < NUM_IN; i++) begin
      j = int'(ptr) + i;
      j = (j >= NUM_IN) ? (j - NUM_IN) : j;
      if (req[j] && !gnt_valid) begin
        gnt[j]    = 1'b1;
        gnt_idx   = IW'(j);
        gnt_valid = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Packet-aware N:1 stream multiplexer with a registered output stage.
// Once a channel's first beat is accepted, the mux stays locked on that
// channel until its last beat passes, so packets are never interleaved.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_data    : NUM_IN x WIDTH per-channel data
//   in_valid   : per-channel valid
//   in_last    : per-channel end-of-packet marker
//   in_ready   : per-channel ready (one-hot or zero)
//   out_data   : registered output data
//   out_valid  : registered output valid
//   out_last   : registered output end-of-packet marker
//   out_sel    : source channel of the beat currently on the output
//   out_ready  : downstream ready
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        NUM_IN   = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]             in_valid,
  input  logic [NUM_IN-1:0]             in_last,
  output logic [NUM_IN-1:0]             in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [$clog2(NUM_IN)-1:0]     out_sel,
  input  logic                          out_ready
);

  localparam int IW = $clog2(NUM_IN);

  mux_state_e        state_r;
  mux_state_e        state_nxt_s;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     lock_idx_r;
  logic [IW-1:0]     arb_ptr_s;
  logic [IW-1:0]     arb_idx_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [NUM_IN-1:0] arb_gnt_s;
  logic              arb_vld_s;
  logic              gnt_vld_s;
  logic              load_en_s;
  logic              accept_s;
  logic              acc_last_s;

  // The output register can take a new beat when it is empty or being drained.
  assign load_en_s = !out_valid || out_ready;

  // Fixed priority is the rotating search pinned to a start index of zero.
  assign arb_ptr_s = (ARB_MODE == ARB_RR) ? ptr_r : {IW{1'b0}};

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .req       (in_valid),
    .ptr       (arb_ptr_s),
    .gnt       (arb_gnt_s),
    .gnt_idx   (arb_idx_s),
    .gnt_valid (arb_vld_s)
  );

  // FSM output decode: grant selection and per-channel ready.
  // While locked, ready goes to the locked channel without looking at its
  // valid, so that channel's ready never depends on its own valid.
  always_comb begin
    in_ready  = {NUM_IN{1'b0}};
    gnt_idx_s = arb_idx_s;
    gnt_vld_s = 1'b0;
    if (rst || !load_en_s) begin
      in_ready = {NUM_IN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          in_ready  = arb_gnt_s;
          gnt_idx_s = arb_idx_s;
          gnt_vld_s = arb_vld_s;
        end
        LOCKED: begin
          in_ready[lock_idx_r] = 1'b1;
          gnt_idx_s            = lock_idx_r;
          gnt_vld_s            = 1'b1;
        end
        default: begin
          in_ready  = {NUM_IN{1'b0}};
          gnt_vld_s = 1'b0;
        end
      endcase
    end
  end

  assign accept_s   = gnt_vld_s && |(in_ready & in_valid);
  assign acc_last_s = in_last[gnt_idx_s];

  // FSM next-state: lock on a non-last first beat, unlock on an accepted last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !acc_last_s) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && acc_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Lock index capture and round-robin pointer advance at end of packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_idx_r <= {IW{1'b0}};
      ptr_r      <= {IW{1'b0}};
    end else begin
      if (accept_s && (state_r == IDLE)) begin
        lock_idx_r <= gnt_idx_s;
      end
      if (accept_s && acc_last_s && (ARB_MODE == ARB_RR)) begin
        ptr_r <= IW'(wrap_inc(int'(gnt_idx_s), NUM_IN));
      end
    end
  end

  // Output register; payload holds whenever nothing new is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_last  <= 1'b0;
      out_sel   <= {IW{1'b0}};
    end else if (load_en_s) begin
      out_valid <= accept_s;
      if (accept_s) begin
        out_data <= in_data[gnt_idx_s];
        out_last <= acc_last_s;
        out_sel  <= gnt_idx_s;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Directed scenarios followed by randomized traffic for stream_mux_rr
// (NUM_IN=4, WIDTH=8). A packet-level reference model tracks the locked
// channel, the rotating priority start and the output register contents.
// A second instance in fixed-priority mode shares the inputs.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_last;
  logic              out_ready;

  logic [N-1:0]      in_ready;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_last;
  logic [1:0]        out_sel;

  logic [N-1:0]      f_in_ready;
  logic [W-1:0]      f_out_data;
  logic              f_out_valid;
  logic              f_out_last;
  logic [1:0]        f_out_sel;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(ARB_RR)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(ARB_FIXED)) dut_fixed (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(f_in_ready), .out_data(f_out_data),
    .out_valid(f_out_valid), .out_last(f_out_last), .out_sel(f_out_sel),
    .out_ready(out_ready)
  );

  int chk_total = 0;
  int chk_fail  = 0;

  // Reference model: -1 means no packet in progress.
  int         m_lock = -1;
  int         m_ptr  = 0;
  logic       m_ov   = 1'b0;
  logic [7:0] m_od   = 8'h00;
  logic       m_ol   = 1'b0;
  int         m_os   = 0;
  logic [N-1:0] acc_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total++;
    assert (obs === exp) else begin
      chk_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Which channel the spec's rules would serve now (-1: none).
  function automatic int pick();
    if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check acceptance before the edge, advance the model, check outputs after.
  task automatic tick();
    int g;
    bit was_rst;
    bit load;
    logic [N-1:0] exp_acc;
    #1;
    g = -1;
    exp_acc = '0;
    was_rst = rst;
    load = !m_ov || out_ready;
    if (was_rst) begin
      check("rst_in_ready", 32'(in_ready), 32'(0));
    end else begin
      g = pick();
      if (load && g >= 0) exp_acc[g] = 1'b1;
      check("accept", 32'(in_ready & in_valid), 32'(exp_acc));
      check("ready_onehot0", 32'($onehot0(in_ready)), 32'(1));
    end
    acc_seen = in_ready & in_valid;
    @(posedge clk);
    if (was_rst) begin
      m_lock = -1; m_ptr = 0; m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_os = 0;
    end else if (load) begin
      if (g >= 0) begin
        m_ov = 1'b1; m_od = in_data[g]; m_ol = in_last[g]; m_os = g;
        if (in_last[g]) begin
          m_lock = -1;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock = g;
        end
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (was_rst) begin
      check("rst_out_data", 32'(out_data), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      check("rst_out_sel", 32'(out_sel), 32'(0));
    end else if (m_ov) begin
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_last", 32'(out_last), 32'(m_ol));
      check("out_sel", 32'(out_sel), 32'(m_os));
    end
  endtask

  logic [N-1:0] gv, gl;
  logic [7:0]   gd [N];
  int           seq [N];

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Single-beat packets on every channel rotate 0,1,2,3,0.
    for (int i = 0; i < N; i++) in_data[i] = 8'(8'h10 + i);
    in_valid = 4'hF; in_last = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_seq_sel", 32'(out_sel), 32'(k % 4));
      check("rr_seq_data", 32'(out_data), 32'(8'h10 + k % 4));
    end

    // Move the pointer to 2 with a single beat from ch1, then lock on ch2.
    in_valid = 4'b0010; tick();
    in_valid = 4'b0101; in_last = 4'b0001;
    in_data[0] = 8'h55; in_data[2] = 8'hA0;
    tick(); check("lock_a0", 32'(out_data), 32'(8'hA0));
    in_data[2] = 8'hA1;
    tick(); check("lock_a1", 32'(out_data), 32'(8'hA1));
    in_data[2] = 8'hA2; in_last = 4'b0101;
    tick(); check("lock_a2", 32'(out_data), 32'(8'hA2));
    check("lock_a2_last", 32'(out_last), 32'(1));
    in_valid = 4'b0001;
    tick(); check("wrap_ch0_sel", 32'(out_sel), 32'(0));
    check("wrap_ch0_data", 32'(out_data), 32'(8'h55));
    in_valid = 4'b0000;
    tick(); check("drain_valid", 32'(out_valid), 32'(0));

    // Backpressure for five cycles in the middle of a ch1 packet.
    in_valid = 4'b0010; in_last = 4'b0000; in_data[1] = 8'hB0;
    tick();
    in_data[1] = 8'hB1;
    tick();
    out_ready = 1'b0; in_data[1] = 8'hB2;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_data", 32'(out_data), 32'(8'hB1));
      check("stall_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    tick(); check("release_b2", 32'(out_data), 32'(8'hB2));
    in_data[1] = 8'hB3; in_last = 4'b0010;
    tick(); check("release_b3", 32'(out_data), 32'(8'hB3));
    in_valid = 4'b0000;
    tick(); check("release_end", 32'(out_valid), 32'(0));

    // Reset while locked on ch1 after two of four beats.
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b0010; in_last = 4'b0000; in_data[1] = 8'hC0;
    tick();
    in_data[1] = 8'hC1;
    tick();
    in_data[1] = 8'hC2; rst = 1'b1;
    tick();
    check("midrst_valid", 32'(out_valid), 32'(0));
    rst = 1'b0;
    in_valid = 4'b1010; in_last = 4'b1010; in_data[1] = 8'hD1; in_data[3] = 8'hD3;
    tick();
    check("postrst_sel", 32'(out_sel), 32'(1));
    check("postrst_data", 32'(out_data), 32'(8'hD1));

    // Fixed priority: ch1 starves ch3.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fixed_valid", 32'(f_out_valid), 32'(1));
      check("fixed_sel", 32'(f_out_sel), 32'(1));
      check("fixed_ready", 32'(f_in_ready), 32'(4'b0010));
    end

    // Random traffic: sources hold a beat until it is taken.
    rst = 1'b1; in_valid = '0; tick(); rst = 1'b0;
    gv = '0; gl = '0;
    for (int ch = 0; ch < N; ch++) begin gd[ch] = 8'h00; seq[ch] = 0; end
    acc_seen = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (!gv[ch] || acc_seen[ch]) begin
          gv[ch] = ($urandom_range(0, 99) < 60);
          gl[ch] = ($urandom_range(0, 3) == 0);
          gd[ch] = 8'(ch * 64 + seq[ch] % 64);
          seq[ch]++;
        end
        in_data[ch] = gd[ch];
      end
      in_valid  = gv;
      in_last   = gl;
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
    tick(); tick();
    check("final_idle", 32'(out_valid), 32'(0));

    $display("%0d/%0d checks passed", chk_total - chk_fail, chk_total);
    $finish;
  end

endmodule
